object_mover: RTL and testbench



---
 rtl/mover_pkg.sv | 26 ++
 rtl/mover_axis.sv | 84 ++++++++
 rtl/object_mover.sv | 171 +++++++++++++++++
 tb/tb_object_mover.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mover_pkg.sv
// Shared types and constants for the sprite motion engine.
// Side bit positions follow the {top,bottom,left,right} packing used on collisionSide and edgeHit.
package mover_pkg;

    typedef enum logic [1:0] {
        EDGE_STOP   = 2'd0,
        EDGE_BOUNCE = 2'd1,
        EDGE_WRAP   = 2'd2
    } edge_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } mover_state_t;

    localparam int SIDE_TOP    = 3;
    localparam int SIDE_BOTTOM = 2;
    localparam int SIDE_LEFT   = 1;
    localparam int SIDE_RIGHT  = 0;

    function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/mover_axis.sv
// One motion axis: collision sign fix, optional acceleration/saturation, position add, edge policy.
// Purely combinational; the caller registers the result on an update frame.
module mover_axis
    import mover_pkg::*;
#(
    parameter int         FP_SHIFT  = 6,
    parameter int         SPAN      = 640,
    parameter int         OBJ       = 32,
    parameter edge_mode_t MODE      = EDGE_STOP,
    parameter int         ACCEL     = 0,
    parameter int         MAX_SPEED = 0,
    parameter bit         SAT_EN    = 1'b0
)(
    input  logic signed [31:0] pos_i,
    input  logic signed [31:0] speed_i,
    input  logic               hit_lo_i,
    input  logic               hit_hi_i,
    output logic signed [31:0] pos_o,
    output logic signed [31:0] speed_o,
    output logic               edge_lo_o,
    output logic               edge_hi_o
);

    localparam int                 HI_PIX  = SPAN - OBJ;
    localparam logic signed [31:0] HI_FP   = 32'(HI_PIX) <<< FP_SHIFT;
    localparam logic signed [31:0] WRAP_FP = 32'(SPAN + OBJ) <<< FP_SHIFT;
    localparam logic signed [31:0] V_MAX   = 32'(MAX_SPEED);
    localparam logic signed [31:0] V_MIN   = -V_MAX;
    localparam logic signed [31:0] V_ACC   = 32'(ACCEL);

    logic signed [31:0] v_fix;
    logic signed [31:0] v_acc;
    logic signed [31:0] pos_sum;
    logic signed [31:0] pix;

    always_comb begin
        v_fix = speed_i;
        if (hit_lo_i && hit_hi_i) begin
            v_fix = '0;
        end else if (hit_lo_i) begin
            v_fix = abs32(speed_i);
        end else if (hit_hi_i) begin
            v_fix = -abs32(speed_i);
        end

        v_acc = v_fix + V_ACC;
        if (SAT_EN) begin
            if (v_acc > V_MAX) begin
                v_acc = V_MAX;
            end else if (v_acc < V_MIN) begin
                v_acc = V_MIN;
            end
        end

        pos_sum   = pos_i + v_acc;
        pix       = pos_sum >>> FP_SHIFT;
        pos_o     = pos_sum;
        speed_o   = v_acc;
        edge_lo_o = 1'b0;
        edge_hi_o = 1'b0;

        if (MODE == EDGE_WRAP) begin
            // Wrap only once the sprite is fully off-screen so it re-enters from the far side.
            if (pix < -OBJ) begin
                pos_o     = pos_sum + WRAP_FP;
                edge_lo_o = 1'b1;
            end else if (pix > SPAN) begin
                pos_o     = pos_sum - WRAP_FP;
                edge_hi_o = 1'b1;
            end
        end else begin
            if (pix < 0) begin
                pos_o     = '0;
                speed_o   = (MODE == EDGE_BOUNCE) ? abs32(v_acc) : '0;
                edge_lo_o = 1'b1;
            end else if (pix > HI_PIX) begin
                pos_o     = HI_FP;
                speed_o   = (MODE == EDGE_BOUNCE) ? -abs32(v_acc) : '0;
                edge_hi_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/object_mover.sv
// Per-object 2-D motion engine: fixed-point position/velocity updated once per startOfFrame,
// with gravity on Y, per-axis edge policy and a sticky collision latch.
//
// state  | meaning
// IDLE   | after reset, waiting for enable; latch held clear
// RUN    | updating position every frame while enabled
// PAUSED | frozen; collisions still latched for the next update
module object_mover
    import mover_pkg::*;
#(
    parameter int FP_SHIFT        = 6,
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 100,
    parameter int INITIAL_X_SPEED = 30,
    parameter int INITIAL_Y_SPEED = 0,
    parameter int GRAVITY         = 0,
    parameter int MAX_Y_SPEED     = 512,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int OBJ_W           = 32,
    parameter int OBJ_H           = 32,
    parameter int X_EDGE_MODE     = 1,
    parameter int Y_EDGE_MODE     = 0
)(
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               load,
    input  logic signed [10:0] loadX,
    input  logic signed [10:0] loadY,
    input  logic signed [31:0] loadXspeed,
    input  logic signed [31:0] loadYspeed,
    input  logic               collision,
    input  logic        [3:0]  collisionSide,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic signed [31:0] Xspeed,
    output logic signed [31:0] Yspeed,
    output logic        [3:0]  edgeHit,
    output logic               moving
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_PAUSED = PAUSED;

    localparam logic signed [31:0] RST_X  = 32'(INITIAL_X) <<< FP_SHIFT;
    localparam logic signed [31:0] RST_Y  = 32'(INITIAL_Y) <<< FP_SHIFT;
    localparam logic signed [31:0] RST_VX = 32'(INITIAL_X_SPEED);
    localparam logic signed [31:0] RST_VY = 32'(INITIAL_Y_SPEED);

    logic        [1:0]  state_q, state_d;
    logic signed [31:0] posx_q, posx_d, posy_q, posy_d;
    logic signed [31:0] vx_q, vx_d, vy_q, vy_d;
    logic        [3:0]  edge_q, edge_d;
    logic        [3:0]  latch_q, latch_d;

    logic               update;
    logic        [3:0]  hit_set;
    logic signed [31:0] nx_pos, nx_vel, ny_pos, ny_vel;
    logic               ex_lo, ex_hi, ey_lo, ey_hi;

    assign update  = startOfFrame && (state_q == ST_RUN) && enable && !load;
    assign hit_set = latch_q | (collision ? collisionSide : 4'b0000);

    mover_axis #(
        .FP_SHIFT (FP_SHIFT),
        .SPAN     (SCREEN_W),
        .OBJ      (OBJ_W),
        .MODE     (edge_mode_t'(X_EDGE_MODE)),
        .ACCEL    (0),
        .MAX_SPEED(0),
        .SAT_EN   (1'b0)
    ) u_axis_x (
        .pos_i    (posx_q),
        .speed_i  (vx_q),
        .hit_lo_i (hit_set[SIDE_LEFT]),
        .hit_hi_i (hit_set[SIDE_RIGHT]),
        .pos_o    (nx_pos),
        .speed_o  (nx_vel),
        .edge_lo_o(ex_lo),
        .edge_hi_o(ex_hi)
    );

    mover_axis #(
        .FP_SHIFT (FP_SHIFT),
        .SPAN     (SCREEN_H),
        .OBJ      (OBJ_H),
        .MODE     (edge_mode_t'(Y_EDGE_MODE)),
        .ACCEL    (GRAVITY),
        .MAX_SPEED(MAX_Y_SPEED),
        .SAT_EN   (1'b1)
    ) u_axis_y (
        .pos_i    (posy_q),
        .speed_i  (vy_q),
        .hit_lo_i (hit_set[SIDE_TOP]),
        .hit_hi_i (hit_set[SIDE_BOTTOM]),
        .pos_o    (ny_pos),
        .speed_o  (ny_vel),
        .edge_lo_o(ey_lo),
        .edge_hi_o(ey_hi)
    );

    always_comb begin
        state_d = state_q;
        if (startOfFrame) begin
            case (state_q)
                ST_IDLE:   if (enable)  state_d = ST_RUN;
                ST_RUN:    if (!enable) state_d = ST_PAUSED;
                ST_PAUSED: if (enable)  state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end

        latch_d = latch_q;
        if (state_q == ST_IDLE || load || update) begin
            latch_d = 4'b0000;
        end else if (collision) begin
            latch_d = latch_q | collisionSide;
        end

        posx_d = posx_q;
        posy_d = posy_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        edge_d = edge_q;
        if (load) begin
            posx_d = {{21{loadX[10]}}, loadX} <<< FP_SHIFT;
            posy_d = {{21{loadY[10]}}, loadY} <<< FP_SHIFT;
            vx_d   = loadXspeed;
            vy_d   = loadYspeed;
        end else if (update) begin
            posx_d = nx_pos;
            posy_d = ny_pos;
            vx_d   = nx_vel;
            vy_d   = ny_vel;
        end
        if (startOfFrame) begin
            edge_d = update ? {ey_lo, ey_hi, ex_lo, ex_hi} : 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            posx_q  <= RST_X;
            posy_q  <= RST_Y;
            vx_q    <= RST_VX;
            vy_q    <= RST_VY;
            edge_q  <= 4'b0000;
            latch_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            edge_q  <= edge_d;
            latch_q <= latch_d;
        end
    end

    assign topLeftX = posx_q[FP_SHIFT +: 11];
    assign topLeftY = posy_q[FP_SHIFT +: 11];
    assign Xspeed   = vx_q;
    assign Yspeed   = vy_q;
    assign edgeHit  = edge_q;
    assign moving   = (state_q == ST_RUN);

endmodule

// File: tb/tb_object_mover.sv
// Bench for object_mover: two instances (default config, and gravity + X wrap) driven in lockstep
// and checked every cycle against an arithmetic reference model.
module tb_object_mover;

    localparam int FP_ONE = 64;

    typedef struct {
        int         px, py, vx, vy;
        logic [3:0] eh, latch;
        int         st;   // 0 idle, 1 running, 2 paused
    } mdl_t;

    typedef struct {
        int ix, iy, ivx, ivy, grav, vmax, xmode, ymode;
    } cfg_t;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame, enable, load, collision;
    logic signed [10:0] loadX, loadY;
    logic signed [31:0] loadXspeed, loadYspeed;
    logic        [3:0]  collisionSide;

    logic signed [10:0] a_x, a_y, b_x, b_y;
    logic signed [31:0] a_vx, a_vy, b_vx, b_vy;
    logic        [3:0]  a_eh, b_eh;
    logic               a_mv, b_mv;

    int compared = 0;
    int mismatched = 0;
    int lx, ly, lvx, lvy;
    cfg_t ca, cb;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    object_mover dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable), .load(load),
        .loadX(loadX), .loadY(loadY), .loadXspeed(loadXspeed), .loadYspeed(loadYspeed),
        .collision(collision), .collisionSide(collisionSide),
        .topLeftX(a_x), .topLeftY(a_y), .Xspeed(a_vx), .Yspeed(a_vy), .edgeHit(a_eh), .moving(a_mv)
    );

    object_mover #(.GRAVITY(8), .MAX_Y_SPEED(40), .X_EDGE_MODE(2), .Y_EDGE_MODE(0)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable), .load(load),
        .loadX(loadX), .loadY(loadY), .loadXspeed(loadXspeed), .loadYspeed(loadYspeed),
        .collision(collision), .collisionSide(collisionSide),
        .topLeftX(b_x), .topLeftY(b_y), .Xspeed(b_vx), .Yspeed(b_vy), .edgeHit(b_eh), .moving(b_mv)
    );

    function automatic int floor64(input int a);
        return (a >= 0) ? a / FP_ONE : -((-a + FP_ONE - 1) / FP_ONE);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic void axis(input int pos, input int v, input bit lo, input bit hi,
                                 input int acc, input int vmax, input bit sat, input int mode,
                                 input int span, input int obj,
                                 output int npos, output int nv, output bit elo, output bit ehi);
        int p;
        elo = 1'b0;
        ehi = 1'b0;
        if (lo && hi)  v = 0;
        else if (lo)   v = iabs(v);
        else if (hi)   v = -iabs(v);
        v = v + acc;
        if (sat && v > vmax)  v = vmax;
        if (sat && v < -vmax) v = -vmax;
        pos = pos + v;
        p = floor64(pos);
        if (mode == 2) begin
            if (p < -obj)     begin pos = pos + (span + obj) * FP_ONE; elo = 1'b1; end
            else if (p > span) begin pos = pos - (span + obj) * FP_ONE; ehi = 1'b1; end
        end else begin
            if (p < 0) begin
                pos = 0; v = (mode == 1) ? iabs(v) : 0; elo = 1'b1;
            end else if (p > span - obj) begin
                pos = (span - obj) * FP_ONE; v = (mode == 1) ? -iabs(v) : 0; ehi = 1'b1;
            end
        end
        npos = pos;
        nv   = v;
    endfunction

    function automatic mdl_t reset_model(input cfg_t c);
        mdl_t m;
        m.px = c.ix * FP_ONE; m.py = c.iy * FP_ONE; m.vx = c.ivx; m.vy = c.ivy;
        m.eh = 4'b0; m.latch = 4'b0; m.st = 0;
        return m;
    endfunction

    function automatic mdl_t step(input mdl_t m, input cfg_t c, input bit s, input bit en,
                                  input bit ld, input bit col, input logic [3:0] side);
        mdl_t n;
        bit upd, xl, xh, yl, yh;
        logic [3:0] hits;
        n    = m;
        upd  = s && (m.st == 1) && en && !ld;
        hits = m.latch | (col ? side : 4'b0);
        if (m.st == 0 || ld || upd) n.latch = 4'b0;
        else if (col)               n.latch = m.latch | side;
        if (s) begin
            if (m.st == 0 && en)       n.st = 1;
            else if (m.st == 1 && !en) n.st = 2;
            else if (m.st == 2 && en)  n.st = 1;
            if (!upd) n.eh = 4'b0;
        end
        if (ld) begin
            n.px = lx * FP_ONE; n.py = ly * FP_ONE; n.vx = lvx; n.vy = lvy;
        end else if (upd) begin
            axis(m.px, m.vx, hits[1], hits[0], 0, 0, 1'b0, c.xmode, 640, 32, n.px, n.vx, xl, xh);
            axis(m.py, m.vy, hits[3], hits[2], c.grav, c.vmax, 1'b1, c.ymode, 480, 32, n.py, n.vy, yl, yh);
            n.eh = {yl, yh, xl, xh};
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input mdl_t m, input logic [10:0] tx, input logic [10:0] ty,
                            input logic [31:0] vx, input logic [31:0] vy, input logic [3:0] eh, input logic mv);
        int t;
        logic [10:0] ex, ey;
        t = floor64(m.px); ex = t[10:0];
        t = floor64(m.py); ey = t[10:0];
        check({nm, ".topLeftX"}, 32'(tx), 32'(ex));
        check({nm, ".topLeftY"}, 32'(ty), 32'(ey));
        check({nm, ".Xspeed"},   vx, m.vx);
        check({nm, ".Yspeed"},   vy, m.vy);
        check({nm, ".edgeHit"},  32'(eh), 32'(m.eh));
        check({nm, ".moving"},   32'(mv), 32'(m.st == 1));
    endtask

    task automatic chk_all();
        chk_inst("a", ma, a_x, a_y, a_vx, a_vy, a_eh, a_mv);
        chk_inst("b", mb, b_x, b_y, b_vx, b_vy, b_eh, b_mv);
    endtask

    task automatic tick(input bit s, input bit ld, input bit col, input logic [3:0] side);
        startOfFrame = s; load = ld; collision = col; collisionSide = side;
        @(posedge clk);
        ma = step(ma, ca, s, enable, ld, col, side);
        mb = step(mb, cb, s, enable, ld, col, side);
        #1;
        startOfFrame = 1'b0; load = 1'b0; collision = 1'b0; collisionSide = 4'b0;
        chk_all();
    endtask

    task automatic frame();
        tick(1'b1, 1'b0, 1'b0, 4'b0);
    endtask

    task automatic set_load(input int x, input int y, input int vx, input int vy);
        lx = x; ly = y; lvx = vx; lvy = vy;
        loadX = x[10:0]; loadY = y[10:0]; loadXspeed = vx; loadYspeed = vy;
    endtask

    task automatic do_load(input int x, input int y, input int vx, input int vy);
        set_load(x, y, vx, vy);
        tick(1'b0, 1'b1, 1'b0, 4'b0);
    endtask

    initial begin
        int held;
        bit found;
        ca = '{280, 100, 30, 0, 0, 512, 1, 0};
        cb = '{280, 100, 30, 0, 8, 40, 2, 0};
        resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; load = 1'b0; collision = 1'b0;
        collisionSide = 4'b0;
        set_load(0, 0, 0, 0);
        ma = reset_model(ca);
        mb = reset_model(cb);
        #22 resetN = 1'b1;
        #1 chk_all();

        // IDLE -> RUN with no motion, then 64 frames of drift
        enable = 1'b1;
        frame();
        check("plan.idle_run_x", 32'(a_x), 32'd280);
        for (int i = 0; i < 64; i++) frame();
        check("plan.x_after_64", 32'(a_x), 32'd310);
        check("plan.y_after_64", 32'(a_y), 32'd100);

        // bounce at right edge on dut_a
        do_load(600, 100, 640, 0);
        frame();
        check("plan.bounce_x", 32'(a_x), 32'd608);
        check("plan.bounce_vx", a_vx, -32'sd640);
        check("plan.bounce_edge", 32'(a_eh), 32'b0001);
        frame();
        check("plan.bounce_x2", 32'(a_x), 32'd598);

        // gravity ramp and bottom stop on dut_b
        do_load(100, 300, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            frame();
            check("plan.grav_vy", b_vy, 32'((i < 5 ? i : 5) * 8));
        end
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            frame();
            if (mb.eh[2]) begin
                found = 1'b1;
                check("plan.stop_y", 32'(b_y), 32'd448);
                check("plan.stop_vy", b_vy, 32'd0);
                check("plan.stop_edge", 32'(b_eh), 32'b0100);
            end
        end
        check("plan.stop_reached", 32'(found), 32'd1);

        // wrap through the left edge on dut_b
        do_load(-20, 100, -1024, 0);
        frame();
        check("plan.wrap_x", 32'(b_x), 32'd636);
        check("plan.wrap_edge", 32'(b_eh), 32'b0010);

        // collision on the right side
        do_load(200, 100, 30, 0);
        tick(1'b0, 1'b0, 1'b1, 4'b0001);
        frame();
        check("plan.coll_vx", a_vx, -32'sd30);
        check("plan.coll_x", 32'(a_x), 32'd199);
        frame();
        check("plan.coll_next_vx", a_vx, -32'sd30);

        // pause, latched collision, resume
        enable = 1'b0;
        frame();
        held = int'(a_x);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) tick(1'b0, 1'b0, 1'b1, 4'b0010);
            frame();
        end
        check("plan.pause_x", 32'(a_x), 32'(held));
        check("plan.pause_moving", 32'(a_mv), 32'd0);
        enable = 1'b1;
        frame();
        check("plan.resume_vx_held", a_vx, -32'sd30);
        frame();
        check("plan.resume_vx", a_vx, 32'sd30);

        // async reset mid-run
        for (int i = 0; i < 5; i++) frame();
        resetN = 1'b0;
        #1;
        ma = reset_model(ca);
        mb = reset_model(cb);
        chk_all();
        check("plan.reset_x", 32'(a_x), 32'd280);
        @(negedge clk) resetN = 1'b1;
        frame();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            enable = ($urandom_range(7) != 0);
            set_load(int'($urandom_range(760)) - 60, int'($urandom_range(560)) - 60,
                     int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000);
            tick($urandom_range(3) == 0, $urandom_range(31) == 0, $urandom_range(5) == 0,
                 4'($urandom_range(15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
